// File: rtl/pong_engine_if.sv
// Player controls and game status for the pong engine.
// The engine takes the slave side; the board or bench takes the master side.
interface pong_engine_if;
  logic       p_upBtn_p1;
  logic       p_dwnBtn_p1;
  logic       p_upBtn_p2;
  logic       p_dwnBtn_p2;
  logic       p_start;
  logic [3:0] p_score_p1;
  logic [3:0] p_score_p2;
  logic       p_game_over;
  logic       p_serving;

  modport master (
    output p_upBtn_p1, p_dwnBtn_p1,
    output p_upBtn_p2, p_dwnBtn_p2,
    output p_start,
    input  p_score_p1, p_score_p2,
    input  p_game_over, p_serving
  );

  modport slave (
    input  p_upBtn_p1, p_dwnBtn_p1,
    input  p_upBtn_p2, p_dwnBtn_p2,
    input  p_start,
    output p_score_p1, p_score_p2,
    output p_game_over, p_serving
  );
endinterface

// File: rtl/pong_engine.sv
// Two-player pong on a scanned LED matrix.
// Game state advances on a slow tick; the matrix is raster-scanned every clock.
module pong_engine #(
  parameter int WIDTH       = 15,
  parameter int HEIGHT      = 10,
  parameter int PADDLE_LEN  = 3,
  parameter int TICK_BITS   = 19,
  parameter int SCORE_MAX   = 9,
  parameter int POINT_TICKS = 8
) (
  input  logic              p_clk12,
  input  logic              p_rst,
  pong_engine_if.slave      bus,
  output wire [WIDTH-1:0]   p_hLED,
  output wire [HEIGHT-1:0]  p_vLED
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [3:0] X_MID    = 4'(WIDTH / 2);
  localparam logic [3:0] Y_MID    = 4'(HEIGHT / 2);
  localparam logic [3:0] X_LEFT   = 4'd1;
  localparam logic [3:0] X_RIGHT  = 4'(WIDTH - 2);
  localparam logic [3:0] X_LAST   = 4'(WIDTH - 1);
  localparam logic [3:0] Y_LAST   = 4'(HEIGHT - 1);
  localparam logic [3:0] PAD_MAX  = 4'(HEIGHT - PADDLE_LEN);
  localparam logic [3:0] PAD_INIT = 4'((HEIGHT - PADDLE_LEN) / 2);
  localparam logic [3:0] SMAX     = 4'(SCORE_MAX);
  localparam logic [7:0] PT_LAST  = 8'(POINT_TICKS - 1);

  state_t               state;
  logic [4:0]           syncA, syncB;
  logic                 up1, dn1, up2, dn2, start;
  logic [TICK_BITS-1:0] tickCnt;
  logic                 tick;
  logic [3:0]           scanX, scanY;
  logic [WIDTH-1:0]     hOn;
  logic [HEIGHT-1:0]    vOn;
  logic [3:0]           pad1, pad2;
  logic [3:0]           ballX, ballY;
  logic                 vxNeg, vyNeg, serveLeft;
  logic [3:0]           score1, score2;
  logic [7:0]           pointCnt;
  logic                 gameOver, serving;
  logic                 vyN;
  logic [3:0]           yN;
  logic                 showBall, pixLit;

  function automatic logic padHit(input logic [3:0] p, input logic [3:0] y);
    return ({1'b0, y} >= {1'b0, p}) &&
           ({1'b0, y} <= {1'b0, p} + 5'(PADDLE_LEN - 1));
  endfunction

  function automatic logic [3:0] padNext(input logic [3:0] p,
                                         input logic up, input logic dn);
    logic [3:0] n;
    n = p;
    unique case (1'b1)
      (up && !dn && p != 4'd0):    n = p - 4'd1;
      (dn && !up && p != PAD_MAX): n = p + 4'd1;
      default:                     n = p;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] bump(input logic [3:0] s);
    return (s == SMAX) ? s : s + 4'd1;
  endfunction

  assign up1   = syncB[0];
  assign dn1   = syncB[1];
  assign up2   = syncB[2];
  assign dn2   = syncB[3];
  assign start = syncB[4];
  assign tick  = &tickCnt;

  assign showBall = (state == SERVE) || (state == PLAY);
  assign pixLit =
    (showBall && scanX == ballX && scanY == ballY) ||
    (scanX == 4'd0 && padHit(pad1, scanY)) ||
    (scanX == X_LAST && padHit(pad2, scanY));

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      syncA   <= '0;
      syncB   <= '0;
      tickCnt <= '0;
      scanX   <= '0;
      scanY   <= '0;
      hOn     <= '0;
      vOn     <= '0;
    end else begin
      syncA   <= {bus.p_start, bus.p_dwnBtn_p2, bus.p_upBtn_p2,
                  bus.p_dwnBtn_p1, bus.p_upBtn_p1};
      syncB   <= syncA;
      tickCnt <= tickCnt + TICK_BITS'(1);
      hOn     <= pixLit ? (WIDTH'(1) << scanX) : '0;
      vOn     <= pixLit ? (HEIGHT'(1) << scanY) : '0;
      if (scanX == X_LAST) begin
        scanX <= '0;
        scanY <= (scanY == Y_LAST) ? 4'd0 : scanY + 4'd1;
      end else begin
        scanX <= scanX + 4'd1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    assign p_hLED[i] = hOn[i] ? 1'b0 : 1'bz;
  end
  for (genvar i = 0; i < HEIGHT; i++) begin : g_row
    assign p_vLED[i] = vOn[i] ? 1'b1 : 1'bz;
  end

  // Wall bounce first; the paddle test uses the post-bounce row.
  always_comb begin
    vyN = vyNeg;
    if ((ballY == 4'd0 && vyNeg) || (ballY == Y_LAST && !vyNeg))
      vyN = !vyNeg;
    yN = vyN ? ballY - 4'd1 : ballY + 4'd1;
  end

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      state     <= IDLE;
      pad1      <= PAD_INIT;
      pad2      <= PAD_INIT;
      ballX     <= X_MID;
      ballY     <= Y_MID;
      vxNeg     <= 1'b1;
      vyNeg     <= 1'b0;
      serveLeft <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      pointCnt  <= '0;
      gameOver  <= 1'b0;
      serving   <= 1'b0;
    end else begin
      if (tick && (state == SERVE || state == PLAY)) begin
        pad1 <= padNext(pad1, up1, dn1);
        pad2 <= padNext(pad2, up2, dn2);
      end
      unique case (state)
        IDLE, GAMEOVER: begin
          if (start) begin
            score1   <= '0;
            score2   <= '0;
            ballX    <= X_MID;
            ballY    <= Y_MID;
            vxNeg    <= serveLeft;
            vyNeg    <= 1'b0;
            gameOver <= 1'b0;
            serving  <= 1'b1;
            state    <= SERVE;
          end
        end
        SERVE: begin
          if (tick) begin
            serving <= 1'b0;
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            ballY <= yN;
            vyNeg <= vyN;
            if (ballX == X_LEFT && vxNeg) begin
              if (padHit(pad1, yN)) begin
                vxNeg <= 1'b0;
                ballX <= X_LEFT + 4'd1;
              end else begin
                score2    <= bump(score2);
                serveLeft <= 1'b1;
                pointCnt  <= '0;
                state     <= POINT;
              end
            end else if (ballX == X_RIGHT && !vxNeg) begin
              if (padHit(pad2, yN)) begin
                vxNeg <= 1'b1;
                ballX <= X_RIGHT - 4'd1;
              end else begin
                score1    <= bump(score1);
                serveLeft <= 1'b0;
                pointCnt  <= '0;
                state     <= POINT;
              end
            end else begin
              ballX <= vxNeg ? ballX - 4'd1 : ballX + 4'd1;
            end
          end
        end
        POINT: begin
          if (tick) begin
            if (pointCnt == PT_LAST) begin
              if (score1 == SMAX || score2 == SMAX) begin
                gameOver <= 1'b1;
                state    <= GAMEOVER;
              end else begin
                ballX   <= X_MID;
                ballY   <= Y_MID;
                vxNeg   <= serveLeft;
                vyNeg   <= 1'b0;
                serving <= 1'b1;
                state   <= SERVE;
              end
            end else begin
              pointCnt <= pointCnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p_score_p1  = score1;
  assign bus.p_score_p2  = score2;
  assign bus.p_game_over = gameOver;
  assign bus.p_serving   = serving;
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine with a 16-clock game tick.
// Ball, paddles and state are observed each tick; the matrix is scanned frame-wide.
module tb_pong_engine;
  logic p_clk12 = 1'b0;
  logic p_rst   = 1'b1;
  tri1 [14:0] hLED;
  tri0 [9:0]  vLED;
  int nChecks = 0;
  int nFails  = 0;

  pong_engine_if bus();

  pong_engine #(.TICK_BITS(4)) dut (
    .p_clk12 (p_clk12),
    .p_rst   (p_rst),
    .bus     (bus),
    .p_hLED  (hLED),
    .p_vLED  (vLED)
  );

  always #5 p_clk12 = ~p_clk12;

  task automatic checkVal(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge p_clk12);
    #1;
  endtask

  task automatic stepTick();
    int n = 0;
    while (dut.tick !== 1'b1 && n < 64) begin
      @(posedge p_clk12);
      #1;
      n++;
    end
    if (n >= 64) checkVal("tickTimeout", n, 0);
    @(posedge p_clk12);
    #1;
  endtask

  task automatic pulseStart();
    bus.p_start = 1'b1;
    clocks(4);
    bus.p_start = 1'b0;
    clocks(3);
  endtask

  task automatic checkBall(input string tag, input int x, input int y);
    checkVal({tag, "X"}, int'(dut.ballX), x);
    checkVal({tag, "Y"}, int'(dut.ballY), y);
  endtask

  task automatic samplePix(output bit lit, output int col, output int row);
    int nh = 0;
    int nv = 0;
    col = -1;
    row = -1;
    for (int i = 0; i < 15; i++)
      if (hLED[i] === 1'b0) begin nh++; col = i; end
    for (int i = 0; i < 10; i++)
      if (vLED[i] === 1'b1) begin nv++; row = i; end
    lit = (nh == 1 && nv == 1);
  endtask

  task automatic scanFrame(input int top1, input int top2,
                           output int litCnt, output int stray);
    bit lit;
    int c, r;
    litCnt = 0;
    stray  = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge p_clk12);
      #1;
      samplePix(lit, c, r);
      if (lit) begin
        litCnt++;
        if (!((c == 0 && r >= top1 && r < top1 + 3) ||
              (c == 14 && r >= top2 && r < top2 + 3)))
          stray++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xsA[6] = '{6, 5, 4, 3, 2, 1};
    int ysA[6] = '{6, 7, 8, 9, 8, 7};
    int xsC[11] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    int ysC[11] = '{5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5};
    int upExp[4] = '{2, 1, 0, 0};
    int litCnt, stray, c, r;
    bit lit;

    bus.p_upBtn_p1  = 1'b0;
    bus.p_dwnBtn_p1 = 1'b0;
    bus.p_upBtn_p2  = 1'b0;
    bus.p_dwnBtn_p2 = 1'b0;
    bus.p_start     = 1'b0;
    clocks(3);

    checkVal("rstState", int'(dut.state), 0);
    checkVal("rstScore1", bus.p_score_p1, 0);
    checkVal("rstScore2", bus.p_score_p2, 0);
    checkVal("rstOver", bus.p_game_over, 0);
    checkVal("rstServing", bus.p_serving, 0);
    checkVal("rstPad1", int'(dut.pad1), 3);
    checkVal("rstPad2", int'(dut.pad2), 3);
    checkBall("rstBall", 7, 5);
    samplePix(lit, c, r);
    checkVal("rstDark", lit, 0);
    p_rst = 1'b0;

    scanFrame(3, 3, litCnt, stray);
    checkVal("idleLit", litCnt, 6);
    checkVal("idleStray", stray, 0);

    stepTick();
    pulseStart();
    checkVal("serveState", int'(dut.state), 1);
    checkVal("serveFlag", bus.p_serving, 1);
    checkBall("serveA", 7, 5);
    stepTick();
    checkVal("playState", int'(dut.state), 2);
    checkVal("serveFlagOff", bus.p_serving, 0);
    checkBall("playStill", 7, 5);
    for (int p = 0; p < 6; p++) begin
      stepTick();
      checkBall("rallyA", xsA[p], ysA[p]);
    end
    stepTick();
    checkVal("missAState", int'(dut.state), 3);
    checkVal("missAScore2", bus.p_score_p2, 1);
    checkVal("missAScore1", bus.p_score_p1, 0);
    repeat (7) stepTick();
    checkVal("pointHold", int'(dut.state), 3);
    stepTick();
    checkVal("reserveState", int'(dut.state), 1);
    checkVal("reserveFlag", bus.p_serving, 1);

    bus.p_upBtn_p1 = 1'b1;
    clocks(3);
    for (int k = 0; k < 4; k++) begin
      stepTick();
      checkVal("pad1Up", int'(dut.pad1), upExp[k]);
    end
    bus.p_dwnBtn_p1 = 1'b1;
    clocks(3);
    repeat (2) begin
      stepTick();
      checkVal("pad1Both", int'(dut.pad1), 0);
    end
    bus.p_upBtn_p1  = 1'b0;
    bus.p_dwnBtn_p1 = 1'b0;
    clocks(3);
    stepTick();
    stepTick();
    checkVal("missBState", int'(dut.state), 3);
    checkVal("missBScore2", bus.p_score_p2, 2);

    bus.p_dwnBtn_p1 = 1'b1;
    clocks(3);
    repeat (8) stepTick();
    checkVal("pad1Frozen", int'(dut.pad1), 0);
    checkVal("serveCState", int'(dut.state), 1);
    for (int k = 1; k <= 6; k++) begin
      stepTick();
      checkVal("pad1Down", int'(dut.pad1), k);
    end
    bus.p_dwnBtn_p1 = 1'b0;
    clocks(3);
    stepTick();
    checkBall("approach", 1, 7);
    stepTick();
    checkBall("hitLeft", 2, 6);
    checkVal("hitState", int'(dut.state), 2);
    checkVal("hitScore2", bus.p_score_p2, 2);
    for (int p = 0; p < 11; p++) begin
      stepTick();
      checkBall("rallyC", xsC[p], ysC[p]);
    end
    stepTick();
    checkVal("missRState", int'(dut.state), 3);
    checkVal("missRScore1", bus.p_score_p1, 1);
    checkVal("missRX", int'(dut.ballX), 13);

    repeat (8) stepTick();
    checkVal("serveDState", int'(dut.state), 1);
    stepTick();
    stepTick();
    checkBall("serveRight", 8, 6);
    pulseStart();
    checkVal("startIgnored", int'(dut.state), 2);
    checkVal("startKeep1", bus.p_score_p1, 1);
    checkVal("startKeep2", bus.p_score_p2, 2);
    repeat (6) stepTick();
    checkVal("runScore", bus.p_score_p1, 2);
    for (int s = 3; s <= 9; s++) begin
      repeat (16) stepTick();
      checkVal("runScore", bus.p_score_p1, s);
    end
    checkVal("overLate", bus.p_game_over, 0);
    repeat (8) stepTick();
    checkVal("overFlag", bus.p_game_over, 1);
    checkVal("overState", int'(dut.state), 4);
    checkVal("overScore1", bus.p_score_p1, 9);
    checkVal("overScore2", bus.p_score_p2, 2);

    bus.p_dwnBtn_p2 = 1'b1;
    clocks(3);
    repeat (2) stepTick();
    checkVal("pad2Frozen", int'(dut.pad2), 3);
    scanFrame(6, 3, litCnt, stray);
    checkVal("overLit", litCnt, 6);
    checkVal("overStray", stray, 0);

    stepTick();
    pulseStart();
    checkVal("restartState", int'(dut.state), 1);
    checkVal("restartScore1", bus.p_score_p1, 0);
    checkVal("restartScore2", bus.p_score_p2, 0);
    checkVal("restartOver", bus.p_game_over, 0);
    stepTick();
    checkVal("pad2Down", int'(dut.pad2), 4);
    stepTick();
    checkBall("restartServe", 8, 6);
    repeat (3) stepTick();
    checkVal("pad2Sat", int'(dut.pad2), 7);

    for (int n = 0; n < 64 && dut.tick !== 1'b1; n++) begin
      @(posedge p_clk12);
      #1;
    end
    p_rst = 1'b1;
    @(posedge p_clk12);
    #1;
    checkVal("midRstState", int'(dut.state), 0);
    checkVal("midRstScore1", bus.p_score_p1, 0);
    checkVal("midRstServing", bus.p_serving, 0);
    checkVal("midRstPad2", int'(dut.pad2), 3);
    checkBall("midRstBall", 7, 5);
    samplePix(lit, c, r);
    checkVal("midRstDark", lit, 0);
    p_rst = 1'b0;
    bus.p_dwnBtn_p2 = 1'b0;
    clocks(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end
endmodule
